// File: rtl/submod_call_responder_if.sv
// Call channel from a parent block to its submodule responder.
// Latency: none, wires only. call_valid/call_arg go parent->responder, call_ready goes back.
// Backpressure: the parent holds call_valid/call_arg stable until call_ready is seen at an edge.
// Ports: call_valid (1), call_arg (DATA_W), call_ready (1).
interface submod_call_responder_if #(
    parameter int DATA_W = 8
);
    logic              call_valid;
    logic [DATA_W-1:0] call_arg;
    logic              call_ready;

    modport master (output call_valid, output call_arg, input call_ready);
    modport slave  (input call_valid, input call_arg, output call_ready);
endinterface

// File: rtl/submod_call_responder.sv
// Callee side of a parent->submodule call: buffers call arguments and adds one per clock into acc.
// Latency: an accept at edge E lands in acc at E+1, or at E+1+k with k entries queued ahead of it.
// Backpressure: call_ready drops while clear is high, while in reset, or when the FIFO holds DEPTH entries.
// Ports: clock, reset_n (async, active-low), call (slave side of the call channel), clear (sync),
//        acc (running sum), acc_valid (commit strobe), pending (buffered count), overflow (sticky carry).
module submod_call_responder #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    parameter  int SAT    = 0,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    submod_call_responder_if.slave call,
    input  logic                  clear,
    output logic [DATA_W-1:0]     acc,
    output logic                  acc_valid,
    output logic [CNT_W-1:0]      pending,
    output logic                  overflow
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] acc_nxt;

    // Ready depends only on the registered count, clear and reset -- never on call_valid,
    // so the parent may compute call_valid from call_ready without forming a loop.
    // A pop on a full edge does not raise ready; the freed slot is offered next cycle.
    assign call.call_ready = reset_n && !clear && (count < CNT_W'(DEPTH));
    assign push            = call.call_valid && call.call_ready;
    assign pending         = count;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: BUSY exactly while something is buffered
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (push) state_nxt = BUSY;
                BUSY:    if ((count == CNT_W'(1)) && !push) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output logic: commit the head entry on every BUSY edge unless clear wins
    always_comb begin
        pop     = (state == BUSY) && !clear;
        sum     = {1'b0, acc} + {1'b0, mem[rd_ptr]};
        acc_nxt = sum[DATA_W-1:0];
        if ((SAT != 0) && sum[DATA_W]) begin
            acc_nxt = '1;
        end
    end

    // FIFO storage needs no reset: count/pointers decide what is valid
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= call.call_arg;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            acc       <= '0;
            acc_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (clear) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            acc       <= '0;
            acc_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            acc_valid <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                acc    <= acc_nxt;
                if (sum[DATA_W]) begin
                    overflow <= 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_submod_call_responder.sv
// Bench for submod_call_responder: a wrapping and a saturating instance share one stimulus stream.
// Model: a queue of pending args plus one accumulator/overflow per arithmetic mode.
// Directed scenarios pin literal values; a random phase follows.
module tb_submod_call_responder;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int MAXV  = 1 << DW;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b1;
    logic          clear   = 1'b0;
    logic          call_valid = 1'b0;
    logic [DW-1:0] call_arg   = '0;

    logic [DW-1:0] acc0, acc1;
    logic          av0, av1, ovf0, ovf1;
    logic [2:0]    pend0, pend1;

    submod_call_responder_if #(.DATA_W(DW)) bus0 ();
    submod_call_responder_if #(.DATA_W(DW)) bus1 ();

    assign bus0.call_valid = call_valid;
    assign bus0.call_arg   = call_arg;
    assign bus1.call_valid = call_valid;
    assign bus1.call_arg   = call_arg;

    submod_call_responder #(.DATA_W(DW), .DEPTH(DEPTH), .SAT(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .call(bus0), .clear(clear),
        .acc(acc0), .acc_valid(av0), .pending(pend0), .overflow(ovf0));

    submod_call_responder #(.DATA_W(DW), .DEPTH(DEPTH), .SAT(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .call(bus1), .clear(clear),
        .acc(acc1), .acc_valid(av1), .pending(pend1), .overflow(ovf1));

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    int strobes     = 0;
    bit chk_en      = 1'b0;

    // Reference model state, valid after each edge
    int q[$];
    int acc_m [2];
    bit ovf_m [2];
    bit av_m  [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int m = 0; m < 2; m++) begin
            acc_m[m] = 0;
            ovf_m[m] = 1'b0;
            av_m[m]  = 1'b0;
        end
    endtask

    // One clock edge of the reference: pop (from pre-edge queue) then push
    task automatic model_step(output bit accepted);
        bit rdy;
        int h;
        int s;
        accepted = 1'b0;
        if (!reset_n) return;
        rdy = !clear && (q.size() < DEPTH);
        if (clear) begin
            model_reset();
            return;
        end
        if (q.size() > 0) begin
            h = q.pop_front();
            for (int m = 0; m < 2; m++) begin
                s = acc_m[m] + h;
                if (s >= MAXV) begin
                    ovf_m[m] = 1'b1;
                    acc_m[m] = (m == 1) ? MAXV - 1 : s - MAXV;
                end else begin
                    acc_m[m] = s;
                end
                av_m[m] = 1'b1;
            end
        end else begin
            av_m[0] = 1'b0;
            av_m[1] = 1'b0;
        end
        if (call_valid && rdy) begin
            q.push_back(int'(call_arg));
            accepted = 1'b1;
        end
    endtask

    task automatic tick(output bit accepted);
        @(posedge clock);
        model_step(accepted);
        #1;
        strobes += int'(av0);
    endtask

    // Offer one call and hold it until accepted, bounded
    task automatic drive_call(input int arg);
        bit acc_f;
        call_valid = 1'b1;
        call_arg   = DW'(arg);
        acc_f      = 1'b0;
        for (int t = 0; t < 16 && !acc_f; t++) begin
            tick(acc_f);
        end
        if (!acc_f) check("accept_timeout", 32'd0, 32'd1);
        call_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        bit a;
        clear = 1'b1;
        tick(a);
        clear = 1'b0;
    endtask

    // Compare every cycle, away from the active edge
    always @(negedge clock) begin
        if (chk_en) begin
            logic exp_rdy;
            exp_rdy = reset_n && !clear && (q.size() < DEPTH);
            check("ready0",   bus0.call_ready, exp_rdy);
            check("ready1",   bus1.call_ready, exp_rdy);
            check("pending0", pend0, q.size());
            check("pending1", pend1, q.size());
            check("acc0",     acc0, acc_m[0]);
            check("acc1",     acc1, acc_m[1]);
            check("acc_vld0", av0, av_m[0]);
            check("acc_vld1", av1, av_m[1]);
            check("ovf0",     ovf0, ovf_m[0]);
            check("ovf1",     ovf1, ovf_m[1]);
        end
    end

    initial begin
        bit a;
        int maxp;

        // Reset held with a call offered: nothing may be accepted
        #1 reset_n = 1'b0;
        model_reset();
        #1 chk_en  = 1'b1;
        call_valid = 1'b1;
        call_arg   = 8'd33;
        for (int i = 0; i < 3; i++) begin
            tick(a);
            check("rst_ready", bus0.call_ready, 32'd0);
            check("rst_pending", pend0, 32'd0);
            check("rst_acc", acc0, 32'd0);
        end
        reset_n = 1'b1;
        tick(a);
        check("first_edge_accept", a, 32'd1);
        check("first_edge_pending", pend0, 32'd1);
        call_valid = 1'b0;
        tick(a);
        check("first_commit", acc0, 32'd33);
        pulse_clear();

        // Single call, then build 200, then overflow in both modes
        drive_call(72);
        tick(a);
        check("single_acc", acc0, 32'd72);
        check("single_strobe", av0, 32'd1);
        tick(a);
        check("single_strobe_off", av0, 32'd0);
        drive_call(128);
        tick(a);
        check("acc_200", acc0, 32'd200);
        check("ovf_not_yet", ovf0, 32'd0);
        drive_call(72);
        tick(a);
        check("wrap_acc", acc0, 32'd16);
        check("wrap_ovf", ovf0, 32'd1);
        check("sat_acc", acc1, 32'd255);
        check("sat_ovf", ovf1, 32'd1);

        // Back-to-back calls 1..6
        pulse_clear();
        strobes = 0;
        maxp    = 0;
        for (int k = 1; k <= 6; k++) begin
            drive_call(k);
            if (int'(pend0) > maxp) maxp = int'(pend0);
        end
        for (int i = 0; i < 6; i++) tick(a);
        check("b2b_acc", acc0, 32'd21);
        check("b2b_strobes", strobes, 32'd6);
        check("b2b_pending_bound", maxp <= DEPTH, 32'd1);

        // Clear with a call buffered and another offered
        drive_call(5);
        check("clr_setup_pending", pend0, 32'd1);
        clear      = 1'b1;
        call_valid = 1'b1;
        call_arg   = 8'd9;
        #1 check("clr_ready_low", bus0.call_ready, 32'd0);
        tick(a);
        check("clr_no_accept", a, 32'd0);
        check("clr_pending", pend0, 32'd0);
        check("clr_acc", acc0, 32'd0);
        check("clr_strobe", av0, 32'd0);
        clear      = 1'b0;
        call_valid = 1'b0;
        tick(a);
        check("clr_no_commit", acc0, 32'd0);
        check("clr_ovf", ovf0, 32'd0);

        // Async reset between edges with a call buffered
        drive_call(30);
        tick(a);
        drive_call(50);
        check("arst_setup_acc", acc0, 32'd30);
        @(negedge clock);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("arst_acc", acc0, 32'd0);
        check("arst_pending", pend0, 32'd0);
        check("arst_ready", bus0.call_ready, 32'd0);
        call_valid = 1'b1;
        call_arg   = 8'd7;
        tick(a);
        tick(a);
        check("arst_no_commit", acc0, 32'd0);
        reset_n = 1'b1;
        tick(a);
        check("arst_release_accept", a, 32'd1);
        call_valid = 1'b0;
        tick(a);
        check("arst_release_acc", acc0, 32'd7);

        // Random traffic with held-until-accepted calls and occasional clears
        a = 1'b1;
        for (int n = 0; n < 600; n++) begin
            if (!(call_valid && !a)) begin
                call_valid = ($urandom_range(0, 3) != 0);
                call_arg   = DW'($urandom_range(0, MAXV - 1));
            end
            clear = ($urandom_range(0, 39) == 0);
            tick(a);
        end
        clear      = 1'b0;
        call_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick(a);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
